// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared operand width, accumulator width and select codes for the divider
package div_pkg;
   localparam int DIV_WIDTH = 8;
   localparam int ACC_W     = DIV_WIDTH + 2;

   localparam logic [1:0] SEL_HOLD = 2'd0;
   localparam logic [1:0] SEL_ALU  = 2'd1;
   localparam logic [1:0] SEL_CLR  = 2'd2;
   localparam logic [1:0] SEL_KEEP = 2'd3;

   function automatic int acc_width(input int w);
      return w + 2;
   endfunction
endpackage

// File: rtl/div_addsub.sv
// rtl/div_addsub.sv - combinational adder/subtractor for the partial remainder
module div_addsub #(
   parameter int W = 10
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_sub,
   output logic [W-1:0] o_y
);
   assign o_y = i_sub ? (i_a - i_b) : (i_a + i_b);
endmodule

// File: rtl/div_datapath.sv
// rtl/div_datapath.sv - restoring-division datapath driven by the divider controller strobes
// Optional divide-by-zero detection is enabled with `define DIV_ZERO_DETECT_EN.
module div_datapath
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             add,
   input  logic             shift,
   input  logic             inbit,
   input  logic [1:0]       sel,
   input  logic             valid,
   input  logic [WIDTH-1:0] dividend_in,
   input  logic [WIDTH-1:0] divisor_in,
   output logic             sign,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
`ifdef DIV_ZERO_DETECT_EN
   output logic             div_zero,
`endif
   output logic             done
);
   localparam int AW = acc_width(WIDTH);

   logic [AW-1:0]    r_a;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_d;
   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_done;
   logic             r_valid_prev;

   logic             w_is_alu;
   logic             w_sub;
   logic             w_inbit;
   logic             w_valid_rise;
   logic [AW-1:0]    w_d_ext;
   logic [AW-1:0]    w_alu;
   logic [AW-1:0]    w_a_sel;

   // Ignored strobes are masked so an undriven add/inbit never reaches a register.
   assign w_is_alu     = (sel == SEL_ALU);
   assign w_sub        = ~(add & w_is_alu);
   assign w_inbit      = inbit & shift;
   assign w_valid_rise = valid & ~r_valid_prev;
   assign w_d_ext      = {2'b00, r_d};

   div_addsub #(.W(AW)) u_addsub (
      .i_a   (r_a),
      .i_b   (w_d_ext),
      .i_sub (w_sub),
      .o_y   (w_alu)
   );

   always_comb begin
      w_a_sel = r_a;
      case (sel)
         SEL_ALU:  w_a_sel = w_alu;
         SEL_CLR:  w_a_sel = '0;
         SEL_HOLD: w_a_sel = r_a;
         SEL_KEEP: w_a_sel = r_a;
         default:  w_a_sel = r_a;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a <= '0;
         r_q <= '0;
         r_d <= '0;
      end else if (load) begin
         r_d <= divisor_in;
         if (shift) begin
            r_a <= {{(AW-1){1'b0}}, dividend_in[WIDTH-1]};
            r_q <= {dividend_in[WIDTH-2:0], w_inbit};
         end else begin
            r_a <= '0;
            r_q <= dividend_in;
         end
      end else if (shift) begin
         r_a <= {w_a_sel[WIDTH:0], r_q[WIDTH-1]};
         r_q <= {r_q[WIDTH-2:0], w_inbit};
      end else begin
         r_a <= w_a_sel;
      end
   end

`ifdef DIV_ZERO_DETECT_EN
   logic             r_div_zero;
   logic [WIDTH-1:0] r_dividend_lat;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div_zero     <= 1'b0;
         r_dividend_lat <= '0;
      end else if (load) begin
         r_div_zero     <= (divisor_in == '0);
         r_dividend_lat <= dividend_in;
      end
   end

   assign div_zero = r_div_zero;
`endif

   // Result capture samples the pre-load A/Q even when a load lands on the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_quotient   <= '0;
         r_remainder  <= '0;
         r_done       <= 1'b0;
         r_valid_prev <= 1'b0;
      end else begin
         r_valid_prev <= valid;
         r_done       <= w_valid_rise;
         if (w_valid_rise) begin
`ifdef DIV_ZERO_DETECT_EN
            if (r_div_zero) begin
               r_quotient  <= '1;
               r_remainder <= r_dividend_lat;
            end else begin
               r_quotient  <= r_q;
               r_remainder <= r_a[WIDTH:1];
            end
`else
            r_quotient  <= r_q;
            r_remainder <= r_a[WIDTH:1];
`endif
         end
      end
   end

   assign sign      = r_a[AW-1];
   assign quotient  = r_quotient;
   assign remainder = r_remainder;
   assign done      = r_done;
endmodule

// File: tb/tb_div_datapath.sv
// tb/tb_div_datapath.sv - directed bench driving controller-style strobe sequences into div_datapath
module tb_div_datapath;
   import div_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       load, add, shift, inbit, valid;
   logic [1:0] sel;
   logic [7:0] dividend_in, divisor_in;
   logic       sign, done;
   logic [7:0] quotient, remainder;
`ifdef DIV_ZERO_DETECT_EN
   logic       div_zero;
`endif

   int checks   = 0;
   int failures = 0;
   int done_cnt;

   div_datapath #(.WIDTH(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .add         (add),
      .shift       (shift),
      .inbit       (inbit),
      .sel         (sel),
      .valid       (valid),
      .dividend_in (dividend_in),
      .divisor_in  (divisor_in),
      .sign        (sign),
      .quotient    (quotient),
      .remainder   (remainder),
`ifdef DIV_ZERO_DETECT_EN
      .div_zero    (div_zero),
`endif
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic idle();
      load  = 1'b0;
      shift = 1'b0;
      inbit = 1'b0;
      add   = 1'b0;
      sel   = SEL_HOLD;
   endtask

   // Pre-shift load followed by n_iter subtract / restore-or-keep pairs.
   task automatic compute(input logic [7:0] dvd, input logic [7:0] dvs, input int n_iter);
      load = 1'b1; shift = 1'b1; inbit = 1'b0; sel = SEL_HOLD; add = 1'b0;
      dividend_in = dvd; divisor_in = dvs;
      tick();
      load = 1'b0;
      for (int i = 0; i < n_iter; i++) begin
         sel = SEL_ALU; add = 1'b0; shift = 1'b0; inbit = 1'bx;
         tick();
         if (sign) begin
            sel = SEL_ALU; add = 1'b1; shift = 1'b1; inbit = 1'b0;
         end else begin
            sel = SEL_KEEP; add = 1'bx; shift = 1'b1; inbit = 1'b1;
         end
         tick();
      end
      idle();
   endtask

   task automatic capture(input string tag, input logic [7:0] q_exp, input logic [7:0] r_exp);
      valid = 1'b1;
      tick();
      chk({tag, "_done"}, done, 1);
      chk({tag, "_q"}, quotient, q_exp);
      chk({tag, "_r"}, remainder, r_exp);
      valid = 1'b0;
      tick();
      chk({tag, "_done_low"}, done, 0);
   endtask

   initial begin
      reset = 1'b1; valid = 1'b0; dividend_in = '0; divisor_in = '0;
      idle();
      tick();
      chk("rst_sign", sign, 0);
      chk("rst_q", quotient, 0);
      chk("rst_r", remainder, 0);
      chk("rst_done", done, 0);
      reset = 1'b0;
      tick();

      // 100/7 then hold valid high across a fresh 255/1 run
      compute(8'd100, 8'd7, 8);
      valid = 1'b1;
      tick();
      chk("d100_done", done, 1);
      chk("d100_q", quotient, 14);
      chk("d100_r", remainder, 2);
      done_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done) done_cnt++;
      end
      chk("hold_done_cnt", done_cnt, 0);
      compute(8'd255, 8'd1, 8);
      chk("hold_done", done, 0);
      chk("hold_q", quotient, 14);
      chk("hold_r", remainder, 2);
      valid = 1'b0;
      tick();
      chk("fall_done", done, 0);
      chk("fall_q", quotient, 14);
      capture("d255", 8'd255, 8'd0);

      compute(8'd5, 8'd9, 8);
      capture("d5", 8'd0, 8'd5);

      // A=1 after pre-shifting 0x80; subtract 9 goes negative, restore brings back 1<<1
      compute(8'h80, 8'd9, 0);
      sel = SEL_ALU; add = 1'b0; shift = 1'b0;
      tick();
      chk("sub_sign", sign, 1);
      sel = SEL_ALU; add = 1'b1; shift = 1'b1; inbit = 1'b0;
      tick();
      chk("restore_sign", sign, 0);
      idle();
      capture("restore", 8'd0, 8'd1);

      // Asynchronous reset part-way through 200/3
      compute(8'd200, 8'd3, 3);
      sel = SEL_ALU; add = 1'b0;
      #3;
      reset = 1'b1;
      #1;
      chk("mid_rst_sign", sign, 0);
      chk("mid_rst_q", quotient, 0);
      chk("mid_rst_r", remainder, 0);
      chk("mid_rst_done", done, 0);
      idle();
      tick();
      reset = 1'b0;
      tick();

      // Valid edge coinciding with the 200/3 load captures the previous 5/9 result
      compute(8'd5, 8'd9, 8);
      valid = 1'b1;
      compute(8'd200, 8'd3, 8);
      chk("ld_edge_q", quotient, 0);
      chk("ld_edge_r", remainder, 5);
      valid = 1'b0;
      tick();
      capture("d200", 8'd66, 8'd2);

`ifdef DIV_ZERO_DETECT_EN
      compute(8'd77, 8'd0, 8);
      chk("dz_flag", div_zero, 1);
      capture("dz", 8'hFF, 8'd77);
      compute(8'd77, 8'd7, 8);
      chk("dz_clear", div_zero, 0);
      capture("d77", 8'd11, 8'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/div_datapath.md
Name: div_datapath

Overview:
- Restoring-division datapath. It is the responder to the divider controller.
- Consumes the controller's load/add/shift/inbit/sel/valid strobes and returns the sign of the partial remainder.
- Holds the divisor (D), accumulator (A) and quotient shift register (Q).
- On valid, registers the final quotient and remainder for the downstream consumer.

Parameters:
- WIDTH, 8, operand width in bits. Dividend, divisor, quotient and remainder are all WIDTH bits.

Ports:
- clk  input  1  clock, rising-edge
- reset  input  1  asynchronous, active-high
- load  input  1  capture operands this cycle
- add  input  1  ALU op when sel=SEL_ALU: 1 = A+D, 0 = A-D
- shift  input  1  shift {A,Q} left one bit this cycle
- inbit  input  1  bit shifted into Q[0] when shift=1
- sel  input  2  accumulator source select
- valid  input  1  controller result-valid strobe (level)
- dividend_in  input  WIDTH  dividend operand, sampled when load=1
- divisor_in  input  WIDTH  divisor operand, sampled when load=1
- sign  output  1  A[WIDTH+1], combinational from the register
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder
- done  output  1  one-cycle pulse on the rising edge of valid

Behaviour:
- Reset (async): A, Q, D, quotient, remainder, done all go to 0, so sign=0. The valid-edge history flop clears to 0. Reset mid-operation aborts immediately with no residue.
- A is WIDTH+2 bits, two's complement. D and Q are WIDTH bits.
- Precedence: load > sel/shift.
- load=1, shift=0: D<=divisor_in, A<=0, Q<=dividend_in.
- load=1, shift=1 (pre-shift):
  - D<=divisor_in
  - A<=zero-extended dividend_in[WIDTH-1]
  - Q<={dividend_in[WIDTH-2:0], inbit}
- load=0: first form A_sel from sel:
  - SEL_HOLD(0): A
  - SEL_ALU(1): A±D at WIDTH+2 bits, D zero-extended
  - SEL_CLR(2): 0
  - SEL_KEEP(3): A
- Then apply shift:
  - shift=1: A<={A_sel[WIDTH:0], Q[WIDTH-1]} and Q<={Q[WIDTH-2:0], inbit}.
  - shift=0: A<=A_sel and Q holds.
- Don't-cares: add is ignored unless sel=SEL_ALU. inbit is ignored unless shift=1. X/Z on an ignored input must not propagate into any register; gate them explicitly.
- Latency: from the load cycle, WIDTH iterations of (SEL_ALU subtract; then restore-or-keep with shift), 2 cycles each. After that, Q holds the quotient and remainder = A[WIDTH:1].
- valid edge (valid=1 and previous valid=0):
  - Next edge: quotient<=Q, remainder<=A[WIDTH:1], done=1 for exactly one cycle.
  - valid held high: outputs stay stable and done stays 0.
  - valid falling: no effect.
- load and a valid edge in the same cycle: capture uses the pre-load A/Q, and the load proceeds.
- sel=SEL_ALU and shift together: ALU result first, then the shift, matching the formulas above.
- Overflow: restoring sequence guarantees A_sel fits in WIDTH+2 bits, so no saturation is required.

Optional Feature:
- Macro DIV_ZERO_DETECT_EN.
- Defined:
  - Adds output div_zero (1 bit, reset 0). It is registered at load from divisor_in==0 and held until the next load.
  - At the valid edge with div_zero=1, force quotient<=all-ones and remainder<=the dividend latched at load. This adds a WIDTH-bit register.
- Undefined: no div_zero port, no extra register. Divide-by-zero yields whatever the iteration produces.

Decomposition:
- Package div_pkg holds:
  - default WIDTH
  - SEL_HOLD/SEL_ALU/SEL_CLR/SEL_KEEP 2-bit constants, shared with the controller
  - ACC_W = WIDTH+2
- One sub-module: div_addsub, a combinational WIDTH+2 adder/subtractor (a, b, sub -> y).

Test Plan:
- Full controller-style sequence 100/7 (WIDTH=8) -> done pulses once; quotient=14, remainder=2.
- 255/1 -> quotient=255, remainder=0. 5/9 -> quotient=0, remainder=5.
- Subtract with A < D -> sign=1 the next cycle. Restore with add=1 -> sign=0 and A equals its pre-subtract value shifted left.
- Assert reset mid-iteration of 200/3 -> all outputs 0 immediately. A fresh 200/3 run -> quotient=66, remainder=2.
- valid held high 5 cycles, then a new load during valid -> done high for exactly 1 cycle. Outputs unchanged until the next valid edge.
- DIV_ZERO_DETECT_EN defined: 77/0 -> div_zero=1, quotient=8'hFF, remainder=77. Next 77/7 -> div_zero=0, quotient=11, remainder=0.
